// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART block transmit path.
//   - tx_seq_state_t : block sequencer FSM state encoding
//   - UART_SYNC_BYTE : sync header byte sent ahead of each block when the
//                      optional header (UART_TX_SEQ_HEADER_EN) is built in
//   - AES_BLOCK_BYTES: bytes in one AES block, default block size
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int         AES_BLOCK_BYTES = 16;
    localparam logic [7:0] UART_SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } tx_seq_state_t;

endpackage

// File: rtl/uart_block_tx_sequencer_serializer.sv
// ---------------------------------------------------------------------------
// uart_byte_serializer
//   Block shift register that presents one byte at a time.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     load       : capture load_data into the shift register
//     load_data  : full block (NUM_BYTES*8 bits)
//     shift      : advance to the next byte (ignored when load is set)
//     first_byte : byte of load_data that would be sent first
//     cur_byte   : byte currently at the output end of the register
//     nxt_byte   : byte that becomes current after one shift
// ---------------------------------------------------------------------------
module uart_byte_serializer #(
    parameter int NUM_BYTES = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [NUM_BYTES*8-1:0] load_data,
    input  logic                   shift,
    output logic [7:0]             first_byte,
    output logic [7:0]             cur_byte,
    output logic [7:0]             nxt_byte
);

    localparam int W = NUM_BYTES * 8;

    logic [W-1:0] shreg_q, shreg_d, shifted;

    // The output end is the top byte for MSB-first, bottom byte otherwise;
    // the register shifts toward that end.
    function automatic logic [7:0] sel_byte(input logic [W-1:0] v);
        return MSB_FIRST ? v[W-1 -: 8] : v[7:0];
    endfunction

    always_comb begin
        shifted = MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
        shreg_d = shreg_q;
        if (load)
            shreg_d = load_data;
        else if (shift)
            shreg_d = shifted;
    end

    always_ff @(posedge clk) begin
        if (rst)
            shreg_q <= '0;
        else
            shreg_q <= shreg_d;
    end

    assign first_byte = sel_byte(load_data);
    assign cur_byte   = sel_byte(shreg_q);
    assign nxt_byte   = sel_byte(shifted);

endmodule

// File: rtl/uart_block_tx_sequencer.sv
// ---------------------------------------------------------------------------
// uart_block_tx_sequencer
//   Accepts one NUM_BYTES*8-bit block over valid/ready and feeds it byte by
//   byte to a UART transmitter (start pulse / data / ready), inserting
//   GAP_CYCLES idle cycles between bytes.
//   Build option: define UART_TX_SEQ_HEADER_EN to send UART_SYNC_BYTE ahead of
//   every block (NUM_BYTES+1 start pulses per block).
//   Ports:
//     uart_clock, uart_reset      : clock, synchronous active-high reset
//     block_data/valid/ready      : upstream block handshake
//     uart_transmit_data          : registered byte to the transmitter
//     uart_tx_start               : one-cycle start pulse
//     uart_tx_ready               : transmitter idle/ready
//     seq_busy                    : block in flight (FSM not IDLE)
//     block_done                  : one-cycle pulse after the last byte
// ---------------------------------------------------------------------------
module uart_block_tx_sequencer
    import uart_pkg::*;
#(
    parameter int NUM_BYTES  = AES_BLOCK_BYTES,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 8
) (
    input  logic                   uart_clock,
    input  logic                   uart_reset,
    input  logic [NUM_BYTES*8-1:0] block_data,
    input  logic                   block_valid,
    output logic                   block_ready,
    output logic [7:0]             uart_transmit_data,
    output logic                   uart_tx_start,
    input  logic                   uart_tx_ready,
    output logic                   seq_busy,
    output logic                   block_done
);

`ifdef UART_TX_SEQ_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam int CNT_W    = $clog2(NUM_BYTES + 1);
    localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    tx_seq_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       data_q, data_d;
    logic             hdr_q, hdr_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             ser_load, ser_shift, start_c, last_byte;
    logic [7:0]       first_byte, cur_byte, nxt_byte;

    uart_byte_serializer #(
        .NUM_BYTES (NUM_BYTES),
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk        (uart_clock),
        .rst        (uart_reset),
        .load       (ser_load),
        .load_data  (block_data),
        .shift      (ser_shift),
        .first_byte (first_byte),
        .cur_byte   (cur_byte),
        .nxt_byte   (nxt_byte)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        data_d    = data_q;
        hdr_d     = hdr_q;
        done_d    = 1'b0;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        start_c   = 1'b0;
        last_byte = 1'b0;

        case (state_q)
            IDLE: begin
                if (block_valid && ready_q) begin
                    ser_load = 1'b1;
                    cnt_d    = '0;
                    hdr_d    = HDR_EN;
                    // Data is loaded on accept so the start pulse can fire
                    // in the very next cycle.
                    data_d   = HDR_EN ? UART_SYNC_BYTE : first_byte;
                    state_d  = START;
                end
            end
            START: begin
                if (uart_tx_ready) begin
                    start_c = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!uart_tx_ready)
                    state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (uart_tx_ready) begin
                    if (hdr_q) begin
                        // Header went out; first data byte is still unshifted.
                        hdr_d  = 1'b0;
                        data_d = cur_byte;
                    end else begin
                        ser_shift = 1'b1;
                        cnt_d     = cnt_q + CNT_W'(1);
                        last_byte = (cnt_q == CNT_W'(NUM_BYTES - 1));
                        // Keep the last byte on the bus rather than loading
                        // the zeros shifted in behind it.
                        if (!last_byte)
                            data_d = nxt_byte;
                    end

                    if (last_byte) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = START;
                    end else begin
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_LAST))
                    state_d = START;
                else
                    gap_d = gap_q + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Registered so ready comes up together with block_done.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge uart_clock) begin
        if (uart_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            data_q  <= 8'h00;
            hdr_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            hdr_q   <= hdr_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Combinational outputs are masked by reset so nothing leaks out in the
    // cycle a reset is first applied mid-block.
    assign block_ready        = ready_q;
    assign uart_transmit_data = data_q;
    assign uart_tx_start      = start_c & ~uart_reset;
    assign seq_busy           = (state_q != IDLE) & ~uart_reset;
    assign block_done         = done_q;

endmodule

// File: tb/tb_uart_block_tx_sequencer.sv
// Bench: two sequencers (MSB-first, LSB-first) share block stimulus; each has
// its own simple UART transmitter model and its own expected-byte queue.
module tb_uart_block_tx_sequencer;

`ifdef UART_TX_SEQ_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NB  = 16;
    localparam int GAP = 8;
    localparam int NPB = NB + HDR;

    localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BLK_B = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] BLK_C = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] bdata = '0;
    logic         bvalid = 1'b0;
    logic         bp = 1'b0;
    logic [1:0]   bready, txs, busy, bdone, rdy_m, txrdy;
    logic [7:0]   txd [2];
    int           bcnt [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pcnt [2] = '{0, 0};
    int last [2] = '{0, 0};
    int tot  [2] = '{0, 0};
    int ndone[2] = '{0, 0};
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    always #5 clk = ~clk;

    assign txrdy = rdy_m & {2{~bp}};

    uart_block_tx_sequencer #(.NUM_BYTES(NB), .MSB_FIRST(1'b1), .GAP_CYCLES(GAP)) u_msb (
        .uart_clock(clk), .uart_reset(rst), .block_data(bdata), .block_valid(bvalid),
        .block_ready(bready[0]), .uart_transmit_data(txd[0]), .uart_tx_start(txs[0]),
        .uart_tx_ready(txrdy[0]), .seq_busy(busy[0]), .block_done(bdone[0]));

    uart_block_tx_sequencer #(.NUM_BYTES(NB), .MSB_FIRST(1'b0), .GAP_CYCLES(GAP)) u_lsb (
        .uart_clock(clk), .uart_reset(rst), .block_data(bdata), .block_valid(bvalid),
        .block_ready(bready[1]), .uart_transmit_data(txd[1]), .uart_tx_start(txs[1]),
        .uart_tx_ready(txrdy[1]), .seq_busy(busy[1]), .block_done(bdone[1]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int i, input logic [7:0] v);
        if (i == 0) exp0.push_back(v);
        else        exp1.push_back(v);
    endtask

    // UART model: ready drops 1 cycle after a start pulse, stays low 10 cycles.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rdy_m[i] <= 1'b1;
                bcnt[i]  <= 0;
            end else if (bcnt[i] != 0) begin
                bcnt[i] <= bcnt[i] - 1;
                if (bcnt[i] == 11)     rdy_m[i] <= 1'b0;
                else if (bcnt[i] == 1) rdy_m[i] <= 1'b1;
            end else if (txs[i]) begin
                bcnt[i] <= 11;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp0.delete();
            exp1.delete();
            pcnt[0] = 0;
            pcnt[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (busy[i]) chk("ready_while_busy", 32'(bready[i]), 32'd0);
                if (bdone[i]) begin
                    chk("pulses_per_block", 32'(pcnt[i]), 32'(NPB));
                    pcnt[i] = 0;
                    ndone[i]++;
                end
                if (txs[i]) begin
                    logic [7:0] e;
                    chk("start_without_ready", 32'(txrdy[i]), 32'd1);
                    if (pcnt[i] > 0) chk("gap_spacing", 32'(cyc - last[i] > GAP), 32'd1);
                    if ((i == 0 ? exp0.size() : exp1.size()) == 0) begin
                        chk("unexpected_start", 32'd1, 32'd0);
                    end else begin
                        e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
                        chk(i == 0 ? "byte_msb_first" : "byte_lsb_first", 32'(txd[i]), 32'(e));
                    end
                    pcnt[i]++;
                    tot[i]++;
                    last[i] = cyc;
                end
                if (bvalid && bready[i]) begin
                    if (HDR != 0) push_exp(i, 8'hA5);
                    for (int b = 0; b < NB; b++)
                        push_exp(i, (i == 0) ? bdata[8*(NB-1-b) +: 8] : bdata[8*b +: 8]);
                end
            end
        end
    end

    task automatic chk_rst_outs();
        for (int i = 0; i < 2; i++) begin
            chk("rst_block_ready", 32'(bready[i]), 32'd0);
            chk("rst_tx_data", 32'(txd[i]), 32'd0);
            chk("rst_tx_start", 32'(txs[i]), 32'd0);
            chk("rst_seq_busy", 32'(busy[i]), 32'd0);
            chk("rst_block_done", 32'(bdone[i]), 32'd0);
        end
    endtask

    // Present a block and hold valid until the accepting edge has passed.
    task automatic send(input logic [127:0] d, input bit keep_valid);
        int n = 0;
        @(posedge clk); #1;
        bdata  = d;
        bvalid = 1'b1;
        while (!bready[0] && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", 32'(bready[0]), 32'd1);
        @(posedge clk); #1;
        if (!keep_valid) bvalid = 1'b0;
    endtask

    // Returns inside the cycle where block_done of the MSB instance is high.
    task automatic wait_done(input int lim);
        int n = 0;
        @(negedge clk); #1;
        while (!bdone[0] && n < lim) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_timeout", 32'(bdone[0]), 32'd1);
    endtask

    initial begin
        int base_t, base_d, n;

        // Reset / idle
        repeat (3) begin
            @(posedge clk); #1;
            chk_rst_outs();
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset_msb", 32'(bready[0]), 32'd1);
        chk("ready_after_reset_lsb", 32'(bready[1]), 32'd1);
        chk("busy_after_reset", 32'(busy), 32'd0);

        // Basic block: checks both bit orders, 1-cycle accept-to-start latency
        send(BLK_A, 1'b0);
        chk("first_start_latency", 32'(txs), 32'd3);
        wait_done(3000);
        chk("ready_with_done", 32'(bready[0]), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("one_done_msb", 32'(ndone[0]), 32'd1);
        chk("one_done_lsb", 32'(ndone[1]), 32'd1);

        // Busy rejection: next block held valid for the whole transfer
        send(BLK_B, 1'b1);
        bdata = BLK_C;
        wait_done(3000);
        chk("ready_in_done_cycle", 32'(bready[0]), 32'd1);
        chk("not_busy_in_done_cycle", 32'(busy[0]), 32'd0);
        @(posedge clk); #1;
        bvalid = 1'b0;
        chk("second_block_accepted", 32'(busy), 32'd3);
        wait_done(3000);
        repeat (5) @(posedge clk);
        #1;
        chk("dones_after_busy_test", 32'(ndone[0]), 32'd3);

        // Backpressure: transmitter not ready for 50 cycles after accept
        bp = 1'b1;
        base_t = tot[0];
        send(BLK_A, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        chk("no_start_under_backpressure", 32'(tot[0] - base_t), 32'd0);
        bp = 1'b0;
        wait_done(3000);
        chk("dones_after_bp", 32'(ndone[0]), 32'd4);

        // Reset mid-block after the 5th byte
        base_t = tot[0];
        send(BLK_B, 1'b0);
        n = 0;
        while (tot[0] < base_t + 5 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("fifth_byte_timeout", 32'(tot[0] - base_t), 32'd5);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk_rst_outs();
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_mid_reset", 32'(bready), 32'd3);
        base_t = tot[0] + tot[1];
        base_d = ndone[0] + ndone[1];
        repeat (300) @(posedge clk);
        #1;
        chk("no_start_after_abandon", 32'(tot[0] + tot[1] - base_t), 32'd0);
        chk("no_done_after_abandon", 32'(ndone[0] + ndone[1] - base_d), 32'd0);
        chk("queue0_drained", 32'(exp0.size()), 32'd0);
        chk("queue1_drained", 32'(exp1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
